// File: rtl/input_debouncer_pkg.sv
// Shared types and limits for the pin debouncer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package debounce_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_PRESS,
    PRESSED,
    WAIT_RELEASE
  } deb_state_t;

  // Below two cycles the count-compare degenerates, so smaller values are clamped.
  localparam int DEBOUNCE_CYCLES_MIN = 2;

endpackage

// File: rtl/input_debouncer_if.sv
// Pin-side bundle: raw button in, debounced level and strobes out.
// Latency: n/a (wiring only).
// Backpressure: none; all signals are free-running levels/strobes.
interface input_debouncer_if;

  logic button_raw;
  logic inputdata_ready;
  logic press_pulse;
  logic release_pulse;

  // Drives the pin and observes the conditioned outputs (board / bench side).
  modport master (
    output button_raw,
    input  inputdata_ready,
    input  press_pulse,
    input  release_pulse
  );

  // Conditioner side.
  modport slave (
    input  button_raw,
    output inputdata_ready,
    output press_pulse,
    output release_pulse
  );

endinterface

// File: rtl/input_debouncer_sync_2ff.sv
// 1-bit two-stage synchroniser for asynchronous pins, reset to a chosen idle level.
// Latency: 2 clk edges from pin to o_q.
// Backpressure: none.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);

  logic r_ff1;
  logic r_ff2;

  // Two back-to-back flops give the first stage a full cycle to resolve metastability.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ff1 <= RST_VAL;
      r_ff2 <= RST_VAL;
    end else begin
      r_ff1 <= i_d;
      r_ff2 <= r_ff1;
    end
  end

  assign o_q = r_ff2;

endmodule

// File: rtl/input_debouncer.sv
// Turns a bouncy async button pin into a clean pressed level plus press/release strobes.
// Latency: level changes DEBOUNCE_CYCLES+3 edges after a stable pin change (2 sync + count).
// Backpressure: none; strobes are single-cycle and not held for a consumer.
module input_debouncer
  import debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input_debouncer_if.slave   bus
);

  localparam int DEB_N = (DEBOUNCE_CYCLES < DEBOUNCE_CYCLES_MIN) ?
                         DEBOUNCE_CYCLES_MIN : DEBOUNCE_CYCLES;
  localparam int CW    = $clog2(DEB_N);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_N - 1);

  logic          w_sync_raw;
  logic          w_s;
  deb_state_t    r_state;
  deb_state_t    w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_ready_nxt;
  logic          r_ready;
  logic          r_press;
  logic          r_release;

  // The raw pin is synchronised before any logic touches it; reset value is the
  // released pin level so the normalised signal starts at "not pressed".
  sync_2ff #(
    .RST_VAL (ACTIVE_LOW)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .i_d   (bus.button_raw),
    .o_q   (w_sync_raw)
  );

  assign w_s = w_sync_raw ^ ACTIVE_LOW;

  // Next-state and counter: a change is accepted only after DEB_N consecutive
  // agreeing samples in a WAIT state; any disagreement drops straight back.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_s) begin
          w_state_nxt = WAIT_PRESS;
          w_cnt_nxt   = '0;
        end
      end
      WAIT_PRESS: begin
        if (!w_s) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = PRESSED;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = r_cnt + 1'b1;
        end
      end
      PRESSED: begin
        if (!w_s) begin
          w_state_nxt = WAIT_RELEASE;
          w_cnt_nxt   = '0;
        end
      end
      WAIT_RELEASE: begin
        if (w_s) begin
          w_state_nxt = PRESSED;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign w_ready_nxt = (w_state_nxt == PRESSED) || (w_state_nxt == WAIT_RELEASE);

  // State and count register; the count never exceeds CNT_LAST so it cannot wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Registered level and edge strobes, all updated on the same edge as the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ready   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_ready   <= w_ready_nxt;
      r_press   <= w_ready_nxt & ~r_ready;
      r_release <= ~w_ready_nxt & r_ready;
    end
  end

  assign bus.inputdata_ready = r_ready;
  assign bus.press_pulse     = r_press;
  assign bus.release_pulse   = r_release;

endmodule

// File: doc/input_debouncer.md
Name: input_debouncer

Overview:
Conditions a raw, asynchronous pushbutton/switch pin into the clean `inputdata_ready` level consumed directly by the control unit's load FSM.
- Synchronises the pin with a 2-flop synchroniser.
- Filters contact bounce with a cycle-count debounce FSM.
- Emits one-cycle press/release strobes for downstream use.
- Sits between the board pin and the control unit, in the same clock domain.

Parameters:
- DEBOUNCE_CYCLES, default 1_000_000 (20 ms @ 50 MHz): consecutive stable synced cycles required to accept a change. Legal range is ≥2; the bench uses 4.
- ACTIVE_LOW, default 1: 1 = pin reads 0 when pressed (board keys); 0 = pin reads 1 when pressed.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- button_raw  in  1  asynchronous pin; polarity per ACTIVE_LOW
- inputdata_ready  out  1  debounced level, 1 = pressed; drives the control unit
- press_pulse  out  1  one-cycle strobe on accepted press
- release_pulse  out  1  one-cycle strobe on accepted release

Behaviour:
- Single clock (clk). Reset is synchronous, active-high. All state changes occur on the rising edge of clk only.
- Reset state: sync flops = released level; FSM = IDLE; counter = 0; inputdata_ready = 0; press_pulse = 0; release_pulse = 0.
- Normalise: p = button_raw XOR ACTIVE_LOW, so p = 1 means pressed.
- p passes through sync_ff1 → sync_ff2; s = sync_ff2 output. Only s is used by the FSM.
- Counter width: $clog2(DEBOUNCE_CYCLES). The counter saturates by construction and never wraps.
- FSM states and transitions:
  - IDLE: s=1 → WAIT_PRESS with cnt=0; otherwise stay.
  - WAIT_PRESS: s=0 → IDLE, cnt=0 (bounce rejected). s=1 and cnt==DEBOUNCE_CYCLES-1 → PRESSED. Otherwise cnt++.
  - PRESSED: s=0 → WAIT_RELEASE with cnt=0; otherwise stay.
  - WAIT_RELEASE: s=1 → PRESSED, cnt=0. s=0 and cnt==DEBOUNCE_CYCLES-1 → IDLE. Otherwise cnt++.
- inputdata_ready = 1 in PRESSED and WAIT_RELEASE; 0 in IDLE and WAIT_PRESS. It is registered (Moore), so it is glitch-free.
- press_pulse: registered; high for exactly the first cycle inputdata_ready is 1.
- release_pulse: registered; high for exactly the first cycle inputdata_ready returns to 0.
- Latency: if p goes 1 before edge k and stays stable, inputdata_ready rises after edge k+2+DEBOUNCE_CYCLES. Release latency is symmetric.
- Pulse width: any p pulse of fewer than DEBOUNCE_CYCLES synced cycles produces no output change and no strobe.
- Press and release strobes are never high in the same cycle. There is at most one strobe per accepted transition.
- Reset mid-count: the next cycle is the reset state. No strobe is emitted, and any partial count is discarded.
- reset held with the button pressed: outputs stay 0. After reset deasserts, a full press debounce (N+2 edges) is required before inputdata_ready = 1.
- No combinational path from button_raw to any output.

Decomposition:
- Package debounce_pkg:
  - typedef enum logic [1:0] {IDLE, WAIT_PRESS, PRESSED, WAIT_RELEASE} deb_state_t
  - localparam minimum DEBOUNCE_CYCLES = 2
- Sub-module sync_2ff: 1-bit, 2-stage synchroniser with reset value parameter.
  - Instantiated once.
  - Reused by other pin inputs in the design.
- FSM, counter and strobe registers live in input_debouncer.

Test Plan (DEBOUNCE_CYCLES=4, ACTIVE_LOW=1):
1. Reset, then hold button_raw=1 for 20 cycles → inputdata_ready=0, no pulses, FSM IDLE.
2. Drive button_raw=0 before edge 10 and hold → inputdata_ready=1 after edge 16 (10+2+4); press_pulse=1 only in cycle after edge 16.
3. Bounce: button_raw=0 for 2 cycles, 1 for 1, 0 for 3, then 1 → inputdata_ready never rises; press_pulse never asserts.
4. From PRESSED, release (button_raw=1) before edge 40 and hold → inputdata_ready=0 after edge 46; release_pulse=1 for exactly that one cycle.
5. Release glitch: while pressed, button_raw=1 for 3 cycles then back to 0 → inputdata_ready stays 1; no release_pulse.
6. Reset mid-count: assert reset=1 for one cycle while in WAIT_PRESS (cnt=2), with button held pressed → outputs 0; press accepted exactly 2+4 edges after reset deasserts.
